// File: rtl/alu.sv
// 8-bit accumulator ALU: eight ops, registered result with zero/carry flags, one-cycle latency.
// No backpressure; en=0 holds res/fz/fc, and rst clears them asynchronously.
module alu (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] fn,
  output logic [7:0] res,
  output logic       fz,
  output logic       fc
);

  typedef enum logic [2:0] {
    FN_ADI = 3'b000,
    FN_ADD = 3'b001,
    FN_SUB = 3'b010,
    FN_AND = 3'b011,
    FN_ORR = 3'b100,
    FN_XOR = 3'b101,
    FN_LSL = 3'b110,
    FN_LSR = 3'b111
  } fn_e;

  logic [7:0] res_q, res_d;
  logic       fz_q, fz_d;
  logic       fc_q, fc_d;
  logic [8:0] sum_d;
  logic [8:0] diff_d;

  // Bit 8 of the 9-bit difference is set exactly when a > b, i.e. a borrow.
  assign sum_d  = {1'b0, b} + {1'b0, a};
  assign diff_d = {1'b0, b} - {1'b0, a};

  always_comb begin
    res_d = 8'h00;
    fc_d  = 1'b0;
    case (fn_e'(fn))
      FN_ADI, FN_ADD: begin
        res_d = sum_d[7:0];
        fc_d  = sum_d[8];
      end
      FN_SUB: begin
        res_d = diff_d[7:0];
        fc_d  = diff_d[8];
      end
      FN_AND: res_d = a & b;
      FN_ORR: res_d = a | b;
      FN_XOR: res_d = a ^ b;
      FN_LSL: begin
        res_d = {a[6:0], 1'b0};
        fc_d  = a[7];
      end
      FN_LSR: begin
        res_d = {1'b0, a[7:1]};
        fc_d  = a[0];
      end
      default: begin
        res_d = 8'h00;
        fc_d  = 1'b0;
      end
    endcase
    fz_d = (res_d == 8'h00);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= 8'h00;
      fz_q  <= 1'b0;
      fc_q  <= 1'b0;
    end else if (en) begin
      res_q <= res_d;
      fz_q  <= fz_d;
      fc_q  <= fc_d;
    end
  end

  assign res = res_q;
  assign fz  = fz_q;
  assign fc  = fc_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: reset, arithmetic, logic, shifts, enable hold, async reset.
module tb_alu;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] a   = 8'h00;
  logic [7:0] b   = 8'h00;
  logic [2:0] fn  = 3'b000;
  logic [7:0] res;
  logic       fz;
  logic       fc;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic [2:0] fn;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       z;
    logic       c;
  } vec_t;

  alu dut (
    .clk(clk),
    .rst(rst),
    .en (en),
    .a  (a),
    .b  (b),
    .fn (fn),
    .res(res),
    .fz (fz),
    .fc (fc)
  );

  initial forever #5 clk = ~clk;

  // Present one op at the falling edge, capture it, and settle just after the rising edge.
  task automatic drive_op(input logic [2:0] f, input logic [7:0] va, input logic [7:0] vb);
    @(negedge clk);
    fn = f;
    a  = va;
    b  = vb;
    en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({res, fz, fc} !== {8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got res=%h fz=%b fc=%b, want res=00 fz=0 fc=0", res, fz, fc);
    end
    // Reset must win over en with a nonzero result pending.
    @(negedge clk);
    fn = 3'b100; a = 8'h33; b = 8'hCC; en = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({res, fz, fc} !== {8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_priority: got res=%h fz=%b fc=%b, want res=00 fz=0 fc=0", res, fz, fc);
    end
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
  endtask

  task automatic test_arith();
    vec_t v[$];
    v.push_back('{"adi_01_00", 3'b000, 8'h01, 8'h00, 8'h01, 1'b0, 1'b0});
    v.push_back('{"add_0c_00", 3'b001, 8'h0C, 8'h00, 8'h0C, 1'b0, 1'b0});
    v.push_back('{"sub_01_01", 3'b010, 8'h01, 8'h01, 8'h00, 1'b1, 1'b0});
    v.push_back('{"add_ff_01", 3'b001, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1});
    v.push_back('{"sub_01_00", 3'b010, 8'h01, 8'h00, 8'hFF, 1'b0, 1'b1});
    v.push_back('{"adi_80_7f", 3'b000, 8'h80, 8'h7F, 8'hFF, 1'b0, 1'b0});
    v.push_back('{"sub_10_30", 3'b010, 8'h10, 8'h30, 8'h20, 1'b0, 1'b0});
    v.push_back('{"adi_80_80", 3'b000, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1});
    v.push_back('{"sub_ff_fe", 3'b010, 8'hFF, 8'hFE, 8'hFF, 1'b0, 1'b1});
    foreach (v[i]) begin
      drive_op(v[i].fn, v[i].a, v[i].b);
      checks++;
      if ({res, fz, fc} !== {v[i].r, v[i].z, v[i].c}) begin
        failures++;
        $display("FAIL %s: got res=%h fz=%b fc=%b, want res=%h fz=%b fc=%b",
                 v[i].name, res, fz, fc, v[i].r, v[i].z, v[i].c);
      end
    end
  endtask

  task automatic test_logic();
    vec_t v[$];
    // Leading carry-out so the first logic op must actively clear fc.
    v.push_back('{"pre_add_carry", 3'b001, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1});
    v.push_back('{"and_0f_ff", 3'b011, 8'h0F, 8'hFF, 8'h0F, 1'b0, 1'b0});
    v.push_back('{"and_f0_0f", 3'b011, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0});
    v.push_back('{"pre_sub_borrow", 3'b010, 8'h01, 8'h00, 8'hFF, 1'b0, 1'b1});
    v.push_back('{"orr_33_cc", 3'b100, 8'h33, 8'hCC, 8'hFF, 1'b0, 1'b0});
    v.push_back('{"orr_00_00", 3'b100, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0});
    v.push_back('{"xor_f0_55", 3'b101, 8'hF0, 8'h55, 8'hA5, 1'b0, 1'b0});
    v.push_back('{"xor_aa_aa", 3'b101, 8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0});
    foreach (v[i]) begin
      drive_op(v[i].fn, v[i].a, v[i].b);
      checks++;
      if ({res, fz, fc} !== {v[i].r, v[i].z, v[i].c}) begin
        failures++;
        $display("FAIL %s: got res=%h fz=%b fc=%b, want res=%h fz=%b fc=%b",
                 v[i].name, res, fz, fc, v[i].r, v[i].z, v[i].c);
      end
    end
  endtask

  task automatic test_shift();
    vec_t v[$];
    v.push_back('{"lsl_0c", 3'b110, 8'h0C, 8'hFF, 8'h18, 1'b0, 1'b0});
    v.push_back('{"lsr_0c", 3'b111, 8'h0C, 8'hFF, 8'h06, 1'b0, 1'b0});
    v.push_back('{"lsl_80", 3'b110, 8'h80, 8'h00, 8'h00, 1'b1, 1'b1});
    v.push_back('{"lsr_01", 3'b111, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1});
    v.push_back('{"lsl_81", 3'b110, 8'h81, 8'h00, 8'h02, 1'b0, 1'b1});
    v.push_back('{"lsr_81", 3'b111, 8'h81, 8'h00, 8'h40, 1'b0, 1'b1});
    v.push_back('{"lsr_a5_b3c", 3'b111, 8'hA5, 8'h3C, 8'h52, 1'b0, 1'b1});
    v.push_back('{"lsl_55_baa", 3'b110, 8'h55, 8'hAA, 8'hAA, 1'b0, 1'b0});
    foreach (v[i]) begin
      drive_op(v[i].fn, v[i].a, v[i].b);
      checks++;
      if ({res, fz, fc} !== {v[i].r, v[i].z, v[i].c}) begin
        failures++;
        $display("FAIL %s: got res=%h fz=%b fc=%b, want res=%h fz=%b fc=%b",
                 v[i].name, res, fz, fc, v[i].r, v[i].z, v[i].c);
      end
    end
  endtask

  task automatic test_enable();
    drive_op(3'b001, 8'h0C, 8'h00);
    checks++;
    if ({res, fz, fc} !== {8'h0C, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL enable_load: got res=%h fz=%b fc=%b, want res=0c fz=0 fc=0", res, fz, fc);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      en = 1'b0;
      fn = (k % 2 == 0) ? 3'b001 : 3'b110;
      a  = 8'hFF - 8'(k);
      b  = 8'h01 + 8'(k);
      @(posedge clk);
      #1;
      checks++;
      if ({res, fz, fc} !== {8'h0C, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL enable_hold_%0d: got res=%h fz=%b fc=%b, want res=0c fz=0 fc=0",
                 k, res, fz, fc);
      end
    end
  endtask

  task automatic test_async_reset();
    drive_op(3'b010, 8'h01, 8'h00);
    checks++;
    if ({res, fz, fc} !== {8'hFF, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL async_preload: got res=%h fz=%b fc=%b, want res=ff fz=0 fc=1", res, fz, fc);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({res, fz, fc} !== {8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset_midcycle: got res=%h fz=%b fc=%b, want res=00 fz=0 fc=0",
               res, fz, fc);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({res, fz, fc} !== {8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset_held: got res=%h fz=%b fc=%b, want res=00 fz=0 fc=0", res, fz, fc);
    end
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({res, fz, fc} !== {8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_release_hold: got res=%h fz=%b fc=%b, want res=00 fz=0 fc=0",
               res, fz, fc);
    end
    drive_op(3'b101, 8'h0F, 8'hF0);
    checks++;
    if ({res, fz, fc} !== {8'hFF, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_recover: got res=%h fz=%b fc=%b, want res=ff fz=0 fc=0", res, fz, fc);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_enable();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
